// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: EX-stage issue and HI/LO result bundle for the MDU
interface mdu_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        md_use;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall;
  modport master (output start, op, rs_val, rt_val, md_use, input hi, lo, busy, done, stall);
  modport slave (input start, op, rs_val, rt_val, md_use, output hi, lo, busy, done, stall);
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle MIPS multiply/divide sequencer owning HI/LO
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic clk,
  input logic reset,
  mdu_ctrl_if.slave bus
);
  localparam logic [3:0] MC = 4'(MULT_CYCLES);
  localparam logic [3:0] DC = 4'(DIV_CYCLES);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic [31:0] a, b, hi_q, lo_q, pend_hi, pend_lo, dvs, dvu, q_s, r_s, q_u, r_u;
  logic signed [31:0] sq, sr;
  logic [63:0] mul_s, mul_u, res;
  logic pend_ok, done_q, busy, issue, last, ovf;
  assign a = bus.rs_val;
  assign b = bus.rt_val;
  assign busy = state == RUN;
  assign issue = state == IDLE && bus.start && !bus.op[2];
  assign last = busy && cnt == 4'd1;
  // full 64-bit result of the op being issued; divisors forced to 1 when the quotient is discarded or special-cased
  always_comb begin
    ovf = a == 32'h8000_0000 && b == 32'hffff_ffff;
    dvs = (b == 32'd0 || ovf) ? 32'd1 : b;
    dvu = b == 32'd0 ? 32'd1 : b;
    mul_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    mul_u = {32'd0, a} * {32'd0, b};
    sq = $signed(a) / $signed(dvs);
    sr = $signed(a) % $signed(dvs);
    q_s = ovf ? 32'h8000_0000 : sq;
    r_s = ovf ? 32'd0 : sr;
    q_u = a / dvu;
    r_u = a % dvu;
    res = bus.op[1:0] == 2'd0 ? mul_s : bus.op[1:0] == 2'd1 ? mul_u : bus.op[1:0] == 2'd2 ? {r_s, q_s} : {r_u, q_u};
  end
  // IDLE -> RUN on a mul/div issue, back to IDLE on the final busy cycle
  always_comb begin
    state_n = issue ? RUN : last ? IDLE : state;
  end
  // state, latency counter, pending result and HI/LO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= 4'd0;
      hi_q <= 32'd0;
      lo_q <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_ok <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state <= state_n;
      done_q <= last;
      if (issue) begin
        cnt <= bus.op[1] ? DC : MC;
        pend_hi <= res[63:32];
        pend_lo <= res[31:0];
        pend_ok <= !(bus.op[1] && b == 32'd0);
      end else if (busy) cnt <= cnt - 4'd1;
      if (last && pend_ok) begin
        hi_q <= pend_hi;
        lo_q <= pend_lo;
      end
      if (state == IDLE && bus.start && bus.op == 3'd4) hi_q <= a;
      if (state == IDLE && bus.start && bus.op == 3'd5) lo_q <= a;
    end
  end
  assign bus.hi = hi_q;
  assign bus.lo = lo_q;
  assign bus.busy = busy;
  assign bus.done = done_q;
  assign bus.stall = bus.md_use & (busy | (bus.start & ~bus.op[2]));
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: scoreboard bench for mdu_ctrl against a plain-arithmetic HI/LO model
module tb_mdu_ctrl;
  localparam int MC = 5;
  localparam int DC = 10;
  logic clk = 0;
  logic reset = 1;
  int checks = 0;
  int errors = 0;
  logic [31:0] mhi = 0;
  logic [31:0] mlo = 0;
  logic [63:0] expq[$];
  logic [63:0] e;
  mdu_ctrl_if bus();
  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sp;
    longint unsigned up;
    case (op)
      3'd0: begin sp = longint'($signed(a)) * longint'($signed(b)); {mhi, mlo} = sp; end
      3'd1: begin up = 64'(a) * 64'(b); {mhi, mlo} = up; end
      3'd2: if (b != 0) begin
        sp = longint'($signed(a)) / longint'($signed(b));
        mlo = sp[31:0];
        sp = longint'($signed(a)) % longint'($signed(b));
        mhi = sp[31:0];
      end
      3'd3: if (b != 0) begin mlo = a / b; mhi = a % b; end
      3'd4: mhi = a;
      3'd5: mlo = a;
      default: ;
    endcase
  endfunction
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got done=1 expected no pending result at %0t", $time);
      end else begin
        e = expq.pop_front();
        chk("result_hilo", {bus.hi, bus.lo}, e);
      end
      chk("done_not_busy", bus.busy, 0);
    end
  end
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic md, input bit inj);
    int nb;
    int n;
    logic [31:0] ohi, olo;
    @(negedge clk);
    bus.start = 1; bus.op = op; bus.rs_val = a; bus.rt_val = b; bus.md_use = md;
    #1 chk("stall_issue", bus.stall, md && op < 4);
    ohi = mhi;
    olo = mlo;
    model(op, a, b);
    if (op < 4) expq.push_back({mhi, mlo});
    @(negedge clk);
    bus.start = 0;
    if (op >= 4) begin
      chk("no_busy", bus.busy, 0);
      chk("mt_hi", bus.hi, mhi);
      chk("mt_lo", bus.lo, mlo);
      return;
    end
    n = op[1] ? DC : MC;
    nb = 0;
    while (bus.busy && nb < 40) begin
      #1 chk("stall_busy", bus.stall, md);
      chk("hold_hilo", {bus.hi, bus.lo}, {ohi, olo});
      nb++;
      if (inj && nb == 2) begin bus.start = 1; bus.op = 5; bus.rs_val = 32'hAAAA5555; end
      else if (inj && nb == 3) begin bus.start = 1; bus.op = 0; bus.rs_val = $urandom; bus.rt_val = $urandom; end
      else bus.start = 0;
      @(negedge clk);
    end
    bus.start = 0;
    chk("busy_cycles", nb, n);
    chk("done_pulse", bus.done, 1);
    #1 chk("stall_done", bus.stall, 0);
    @(negedge clk);
    chk("done_once", bus.done, 0);
  endtask
  initial begin
    logic [2:0] op;
    logic [31:0] a, b;
    int r;
    bus.start = 0; bus.op = 0; bus.rs_val = 0; bus.rt_val = 0; bus.md_use = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    do_op(3'd0, 32'hFFFFFFFD, 32'd5, 1, 1);
    chk("mult_neg_lo", bus.lo, 32'hFFFFFFF1);
    do_op(3'd1, 32'hFFFFFFFF, 32'd2, 0, 0);
    chk("multu_hi", bus.hi, 32'h1);
    do_op(3'd2, 32'hFFFFFFF9, 32'd2, 1, 0);
    chk("div_neg", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFD);
    do_op(3'd3, 32'd7, 32'd2, 0, 0);
    do_op(3'd4, 32'h12345678, 32'd0, 1, 0);
    do_op(3'd2, 32'd99, 32'd0, 1, 0);
    chk("div0_hi", bus.hi, 32'h12345678);
    chk("div0_lo", bus.lo, 32'd3);
    do_op(3'd3, 32'd99, 32'd0, 0, 0);
    do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0);
    chk("div_ovf", {bus.hi, bus.lo}, 64'h00000000_80000000);
    do_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 0, 0);
    do_op(3'd6, 32'hDEADBEEF, 32'd1, 1, 0);
    do_op(3'd5, 32'hCAFEF00D, 32'd0, 1, 0);
    @(negedge clk);
    bus.start = 1; bus.op = 3'd2; bus.rs_val = 32'd100; bus.rt_val = 32'd7; bus.md_use = 0;
    @(negedge clk);
    bus.start = 0;
    repeat (3) @(negedge clk);
    chk("busy_before_abort", bus.busy, 1);
    #2 reset = 1;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_hilo", {bus.hi, bus.lo}, 0);
    chk("abort_done", bus.done, 0);
    mhi = 0;
    mlo = 0;
    @(negedge clk);
    reset = 0;
    repeat (15) begin
      @(negedge clk);
      chk("no_done_after_reset", bus.done, 0);
    end
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      r = $urandom_range(0, 9);
      b = r == 0 ? 32'd0 : r == 1 ? 32'hFFFFFFFF : $urandom;
      if (r == 2) a = 32'h80000000;
      do_op(op, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    repeat (3) @(negedge clk);
    chk("queue_empty", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide sequencer for the pipelined MIPS core. Sits beside the ALU in the EX stage and owns the HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO issues from EX and models fixed multi-cycle latency with a counter FSM.
- Raises a stall to the hazard unit whenever a decode-stage HI/LO instruction would collide with a busy unit.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  EX-stage instruction issues an MDU op this cycle
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
- rs_val  input  32  operand A (dividend / multiplicand / MTHI-MTLO source)
- rt_val  input  32  operand B (divisor / multiplier)
- md_use  input  1  decode-stage instruction is any of MULT*, DIV*, MFHI, MFLO, MTHI, MTLO
- hi  output  32  HI register
- lo  output  32  LO register
- busy  output  1  multiply/divide in flight
- done  output  1  one-cycle pulse in the cycle the result becomes visible in hi/lo
- stall  output  1  freeze IF/ID and bubble EX

Behaviour:
- Reset (async, active-high): hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0, pending result cleared. Asserting reset mid-operation aborts the op; hi/lo return to 0.
- FSM has two states, IDLE and RUN.
- IDLE, start=1, op in 0..3:
  - At this edge, latch the full 64-bit result into pending registers, computed from rs_val/rt_val as sampled at the edge.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to RUN; busy=1 from the next cycle.
- IDLE, start=1, op=4: hi<=rs_val at this edge; no busy.
- IDLE, start=1, op=5: lo<=rs_val at this edge; no busy.
- IDLE, start=1, op=6/7: no effect.
- RUN: the counter decrements each edge.
  - busy stays high for exactly N cycles after the start edge (N = selected latency).
  - At the edge ending the Nth busy cycle: hi/lo <= pending, busy<=0, done<=1 for one cycle, state returns to IDLE.
  - Example, MULT started at edge t: busy high in cycles t+1..t+5; new hi/lo and done visible in cycle t+6.
- hi/lo stay unchanged throughout RUN; an MFHI reaching EX early is prevented by stall, not by the MDU.
- start while busy (protocol violation): ignored entirely for every op, including MTHI/MTLO. The running op completes normally.
- Arithmetic:
  - MULT: signed 32x32 -> 64; hi = upper word, lo = lower word.
  - MULTU: unsigned 32x32 -> 64.
  - DIV: lo = quotient truncated toward zero; hi = remainder carrying the dividend's sign.
  - DIVU: unsigned quotient/remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divisor 0 (DIV or DIVU): full latency is still consumed and done still pulses, but hi/lo keep their prior values.
- stall = md_use & (busy | (start & (op<=3))), purely combinational.
  - Also stalls the cycle of issue, so a back-to-back MFLO never sees stale data.
  - stall never depends on op 4..7.
- done is a registered output and never coincides with busy=1.

Test Plan:
- Reset 2 cycles; start MULT rs=0xFFFFFFFD(-3), rt=5 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1, done high 1 cycle.
- MULTU rs=0xFFFFFFFF, rt=2 -> after 5 busy cycles hi=0x00000001, lo=0xFFFFFFFE.
- DIV rs=0xFFFFFFF9(-7), rt=2 -> 10 busy cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU rs=7, rt=2 -> lo=3, hi=1.
- MTHI 0x12345678, then DIV by 0 -> hi stays 0x12345678 and lo stays unchanged after 10 cycles; done pulses.
- During MULT busy: MTLO 0xAAAA5555 and second MULT both ignored; md_use=1 gives stall=1 every busy cycle and in the issue cycle; stall=0 in the cycle done=1.
- Start DIV; assert reset in busy cycle 4 -> hi=lo=0, busy=0 immediately (asynchronous), with no done pulse after reset release.
